// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle of the hazard-detection inputs and the pipeline-control
//               outputs exchanged between the 5-stage pipeline and the
//               stall/flush controller.
//               master : pipeline side. It drives the register indices, the
//                        valid bits, the taken-branch flag and the memory
//                        request, and observes the control outputs.
//               slave  : controller side (pipe_hazard_ctrl).
//               The CNT_WIDTH parameter must match the one given to
//               pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    // ID-stage operand usage
    logic [3:0]           id_src1;
    logic                 id_src1_valid;
    logic [3:0]           id_src2;
    logic                 id_two_src;
    // EXE-stage producer
    logic [3:0]           exe_dest;
    logic                 exe_wb_en;
    logic                 exe_mem_read;
    // MEM-stage producer
    logic [3:0]           mem_dest;
    logic                 mem_wb_en;
    // Control-flow and memory events
    logic                 exe_branch_taken;
    logic                 mem_req;
    // Controller outputs
    logic                 freeze_if;
    logic                 flush_if;
    logic                 flush_id;
    logic                 freeze_all;
    logic                 mem_done;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output id_src1, id_src1_valid, id_src2, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_read,
        output mem_dest, mem_wb_en,
        output exe_branch_taken, mem_req,
        input  freeze_if, flush_if, flush_id, freeze_all, mem_done,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_src1, id_src1_valid, id_src2, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_read,
        input  mem_dest, mem_wb_en,
        input  exe_branch_taken, mem_req,
        output freeze_if, flush_if, flush_id, freeze_all, mem_done,
        output stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central stall/flush controller for the 5-stage ARM pipeline.
//               - Detects RAW hazards between the instruction in ID and the
//                 producers in EXE and MEM.
//               - Squashes wrong-path fetches on a branch taken in EXE.
//               - Sequences multi-cycle data-memory accesses with a wait-state
//                 FSM (IDLE -> ACCESS -> DONE). The FSM freezes the whole
//                 pipeline for MEM_WAIT_CYCLES cycles per access.
//               - Keeps saturating stall and flush counters for debug.
//               Priority, highest first: memory stall, taken branch, data
//               hazard.
//
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - pipe_hazard_ctrl_if.slave, which carries:
//                      id_src1/id_src1_valid/id_src2/id_two_src (ID operands)
//                      exe_dest/exe_wb_en/exe_mem_read          (EXE producer)
//                      mem_dest/mem_wb_en                       (MEM producer)
//                      exe_branch_taken, mem_req                (events)
//                      freeze_if, flush_if, flush_id, freeze_all, mem_done
//                      stall_count, flush_count                 (perf counters)
//
// Parameters  : MEM_WAIT_CYCLES - frozen cycles per data-memory access
//                                 (0 = single-cycle memory, never stalls)
//               CNT_WIDTH       - width of the performance counters
//
// Build option: HAZARD_FWD_EN - when defined, a forwarding unit is assumed to
//               cover EXE/MEM results, so only a load-use hazard against EXE
//               stalls. When undefined, the design is a full interlock.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_hazard_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The wait counter only has to reach MEM_WAIT_CYCLES-1. Keep at least one
    // bit so the degenerate configurations (0/1/2) still elaborate.
    localparam int c_wait_cnt_w = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES) : 1;

    localparam logic [c_wait_cnt_w-1:0] c_wait_last =
        c_wait_cnt_w'((MEM_WAIT_CYCLES > 0) ? (MEM_WAIT_CYCLES - 1) : 0);
    localparam logic [c_wait_cnt_w-1:0] c_wait_one  = c_wait_cnt_w'(1);

    localparam logic [CNT_WIDTH-1:0]    c_cnt_max   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]    c_cnt_one   = CNT_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Memory wait-state FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_wait_cnt_w-1:0] r_wait_cnt;
    logic [c_wait_cnt_w-1:0] w_next_wait_cnt;

    // FSM-derived raw outputs (before reset gating)
    logic                    w_fsm_freeze;
    logic                    w_fsm_done;

    // Reset-gated control outputs
    logic                    w_freeze_all;
    logic                    w_mem_done;
    logic                    w_freeze_if;
    logic                    w_flush_if;
    logic                    w_flush_id;

    // Hazard detection
    logic                    w_id_reads_exe;
    logic                    w_id_reads_mem;
    logic                    w_hz_exe;
    logic                    w_hz_mem;
    logic                    w_hazard;
    logic                    w_unused;

    // Performance counters
    logic [CNT_WIDTH-1:0]    r_stall_count;
    logic [CNT_WIDTH-1:0]    r_flush_count;
    logic                    w_stall_inc;
    logic                    w_flush_inc;

    // ------------------------------------------------------------------------
    // RAW hazard detection
    // ------------------------------------------------------------------------
    assign w_id_reads_exe = (bus.id_src1_valid & (bus.id_src1 == bus.exe_dest)) |
                            (bus.id_two_src    & (bus.id_src2 == bus.exe_dest));
    assign w_id_reads_mem = (bus.id_src1_valid & (bus.id_src1 == bus.mem_dest)) |
                            (bus.id_two_src    & (bus.id_src2 == bus.mem_dest));

    assign w_hz_exe = bus.exe_wb_en & w_id_reads_exe;
    assign w_hz_mem = bus.mem_wb_en & w_id_reads_mem;

`ifdef HAZARD_FWD_EN
    // Forwarded results cover every EXE/MEM producer except a load still in
    // EXE, whose data does not exist until the end of MEM.
    assign w_hazard = bus.exe_mem_read & w_hz_exe;
    assign w_unused = w_hz_mem;
`else
    // Full interlock: any pending write to a register that ID reads stalls.
    assign w_hazard = w_hz_exe | w_hz_mem;
    assign w_unused = bus.exe_mem_read;
`endif

    // ------------------------------------------------------------------------
    // Memory FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Memory FSM: next state and raw outputs
    // The IDLE cycle that sees mem_req is itself the first frozen cycle. ACCESS
    // therefore counts from 1 up to MEM_WAIT_CYCLES-1, which gives exactly
    // MEM_WAIT_CYCLES frozen cycles followed by one advancing DONE cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_fsm_freeze    = 1'b0;
        w_fsm_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.mem_req) begin
                    if (MEM_WAIT_CYCLES == 0) begin
                        // Single-cycle memory: complete in place, no freeze.
                        w_fsm_done = 1'b1;
                    end else begin
                        w_fsm_freeze = 1'b1;
                        if (MEM_WAIT_CYCLES == 1) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state    = ST_ACCESS;
                            w_next_wait_cnt = c_wait_one;
                        end
                    end
                end
            end

            ST_ACCESS: begin
                // mem_req is not sampled here: once started, an access
                // always runs to completion.
                w_fsm_freeze = 1'b1;
                if (r_wait_cnt == c_wait_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_wait_cnt = r_wait_cnt + c_wait_one;
                end
            end

            ST_DONE: begin
                // The pipeline advances this cycle and moves the memory
                // instruction out of MEM. Its mem_req is ignored so that it
                // does not start the access a second time.
                w_fsm_done   = 1'b1;
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline control with priority: memory stall > branch > hazard.
    // All outputs are forced low while rst is asserted.
    // ------------------------------------------------------------------------
    assign w_freeze_all = w_fsm_freeze & ~rst;
    assign w_mem_done   = w_fsm_done   & ~rst;

    always_comb begin
        w_freeze_if = 1'b0;
        w_flush_if  = 1'b0;
        w_flush_id  = 1'b0;

        if (rst || w_freeze_all) begin
            // Everything holds. A frozen pipeline must not lose the
            // instructions it is holding.
        end else if (bus.exe_branch_taken) begin
            // Wrong-path instructions in IF and ID are discarded. Any hazard
            // the ID instruction raises is therefore irrelevant.
            w_flush_if = 1'b1;
            w_flush_id = 1'b1;
        end else if (w_hazard) begin
            // Hold IF/ID and PC, and push a bubble into EXE.
            w_freeze_if = 1'b1;
            w_flush_id  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    assign w_stall_inc = w_freeze_if | w_freeze_all;
    assign w_flush_inc = w_flush_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall_inc && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_count <= '0;
        end else if (w_flush_inc && (r_flush_count != c_cnt_max)) begin
            r_flush_count <= r_flush_count + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.freeze_if   = w_freeze_if;
    assign bus.flush_if    = w_flush_if;
    assign bus.flush_id    = w_flush_id;
    assign bus.freeze_all  = w_freeze_all;
    assign bus.mem_done    = w_mem_done;
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (W=4, 4-bit counters).
//               It uses a table of single-cycle hazard/branch vectors,
//               hand-written multi-cycle memory/reset/saturation sequences and
//               a randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int W    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    pipe_hazard_ctrl #(
        .MEM_WAIT_CYCLES (W),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] src1; logic v1; logic [3:0] src2; logic two;
        logic [3:0] ed;   logic ewb; logic erd;
        logic [3:0] md;   logic mwb;
        logic br;   logic req;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [2:0] exp_full;   // {freeze_if, flush_if, flush_id}
        logic [2:0] exp_fwd;
    } vec_t;

    // ---------------- reference model state ----------------
    int   m_pos;     // -1: no access; 1..W-1: frozen cycles used; W: completion cycle
    int   m_stall;
    int   m_flush;
    logic e_fi, e_fli, e_fld, e_fa, e_md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v);
        bus.id_src1          = v.src1;
        bus.id_src1_valid    = v.v1;
        bus.id_src2          = v.src2;
        bus.id_two_src       = v.two;
        bus.exe_dest         = v.ed;
        bus.exe_wb_en        = v.ewb;
        bus.exe_mem_read     = v.erd;
        bus.mem_dest         = v.md;
        bus.mem_wb_en        = v.mwb;
        bus.exe_branch_taken = v.br;
        bus.mem_req          = v.req;
    endtask

    function automatic in_t zero_in();
        in_t z;
        z = '{src1:4'd0, v1:1'b0, src2:4'd0, two:1'b0, ed:4'd0, ewb:1'b0,
              erd:1'b0, md:4'd0, mwb:1'b0, br:1'b0, req:1'b0};
        return z;
    endfunction

    function automatic bit id_reads(input logic [3:0] r);
        return (bus.id_src1_valid && (bus.id_src1 == r)) ||
               (bus.id_two_src    && (bus.id_src2 == r));
    endfunction

    function automatic void model_reset();
        m_pos   = -1;
        m_stall = 0;
        m_flush = 0;
    endfunction

    // Expected outputs for the current cycle from the rules, not the RTL.
    function automatic void model_eval();
        bit hz;
        e_fi = 0; e_fli = 0; e_fld = 0; e_fa = 0; e_md = 0;
`ifdef HAZARD_FWD_EN
        hz = bus.exe_wb_en && bus.exe_mem_read && id_reads(bus.exe_dest);
`else
        hz = (bus.exe_wb_en && id_reads(bus.exe_dest)) ||
             (bus.mem_wb_en && id_reads(bus.mem_dest));
`endif
        if (rst) return;
        if (m_pos < 0) begin
            if (bus.mem_req) begin
                if (W == 0) e_md = 1; else e_fa = 1;
            end
        end else if (m_pos < W) begin
            e_fa = 1;
        end else begin
            e_md = 1;
        end
        if (e_fa) begin
        end else if (bus.exe_branch_taken) begin
            e_fli = 1; e_fld = 1;
        end else if (hz) begin
            e_fi = 1; e_fld = 1;
        end
    endfunction

    function automatic void model_update();
        if (e_fi || e_fa) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
        if (e_fli)        m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
        if (m_pos < 0) begin
            if (bus.mem_req && W > 0) m_pos = 1;
        end else if (m_pos < W) begin
            m_pos++;
        end else begin
            m_pos = -1;
        end
    endfunction

    // First half of a cycle: sample at the falling edge and compare with the model.
    task automatic cyc_a(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".freeze_if"},   bus.freeze_if,   e_fi);
        chk({tag, ".flush_if"},    bus.flush_if,    e_fli);
        chk({tag, ".flush_id"},    bus.flush_id,    e_fld);
        chk({tag, ".freeze_all"},  bus.freeze_all,  e_fa);
        chk({tag, ".mem_done"},    bus.mem_done,    e_md);
        chk({tag, ".stall_count"}, bus.stall_count, m_stall);
        chk({tag, ".flush_count"}, bus.flush_count, m_flush);
    endtask

    // Second half: rising edge, advance the model, step off the edge.
    task automatic cyc_b();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        in_t h;
        h = zero_in();
        h.src1 = 4'd3; h.v1 = 1'b1; h.ed = 4'd3; h.ewb = 1'b1; h.erd = 1'b1;
        h.br = 1'b1; h.req = 1'b1;
        apply(h);
        rst = 1'b1;
        #1;
        chk("rst.freeze_if",   bus.freeze_if,   0);
        chk("rst.flush_if",    bus.flush_if,    0);
        chk("rst.flush_id",    bus.flush_id,    0);
        chk("rst.freeze_all",  bus.freeze_all,  0);
        chk("rst.mem_done",    bus.mem_done,    0);
        chk("rst.stall_count", bus.stall_count, 0);
        chk("rst.flush_count", bus.flush_count, 0);
        @(posedge clk);
        #1;
        apply(zero_in());
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        in_t  v;

        tbl[0]  = '{"no_hazard",      '{4'd1,1'b1,4'd2,1'b1, 4'd5,1'b1,1'b0, 4'd6,1'b1, 1'b0,1'b0}, 3'b000, 3'b000};
        tbl[1]  = '{"raw_exe_src1",   '{4'd3,1'b1,4'd0,1'b0, 4'd3,1'b1,1'b0, 4'd0,1'b0, 1'b0,1'b0}, 3'b101, 3'b000};
        tbl[2]  = '{"raw_mem_src1",   '{4'd3,1'b1,4'd0,1'b0, 4'd0,1'b0,1'b0, 4'd3,1'b1, 1'b0,1'b0}, 3'b101, 3'b000};
        tbl[3]  = '{"load_use_exe",   '{4'd3,1'b1,4'd0,1'b0, 4'd3,1'b1,1'b1, 4'd0,1'b0, 1'b0,1'b0}, 3'b101, 3'b101};
        tbl[4]  = '{"load_use_src2",  '{4'd0,1'b0,4'd7,1'b1, 4'd7,1'b1,1'b1, 4'd0,1'b0, 1'b0,1'b0}, 3'b101, 3'b101};
        tbl[5]  = '{"src2_not_read",  '{4'd0,1'b0,4'd7,1'b0, 4'd7,1'b1,1'b1, 4'd0,1'b0, 1'b0,1'b0}, 3'b000, 3'b000};
        tbl[6]  = '{"src1_invalid",   '{4'd3,1'b0,4'd0,1'b0, 4'd3,1'b1,1'b1, 4'd0,1'b0, 1'b0,1'b0}, 3'b000, 3'b000};
        tbl[7]  = '{"no_writeback",   '{4'd3,1'b1,4'd0,1'b0, 4'd3,1'b0,1'b1, 4'd3,1'b0, 1'b0,1'b0}, 3'b000, 3'b000};
        tbl[8]  = '{"branch_hazard",  '{4'd3,1'b1,4'd0,1'b0, 4'd3,1'b1,1'b1, 4'd3,1'b1, 1'b1,1'b0}, 3'b011, 3'b011};
        tbl[9]  = '{"branch_only",    '{4'd1,1'b1,4'd2,1'b1, 4'd5,1'b1,1'b0, 4'd6,1'b1, 1'b1,1'b0}, 3'b011, 3'b011};
        tbl[10] = '{"raw_mem_src2",   '{4'd0,1'b0,4'd9,1'b1, 4'd0,1'b0,1'b0, 4'd9,1'b1, 1'b0,1'b0}, 3'b101, 3'b000};

        rst = 1'b1;
        apply(zero_in());
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // ---------------- table-driven single-cycle vectors ----------------
        for (int i = 0; i < 11; i++) begin
            logic [2:0] exp;
`ifdef HAZARD_FWD_EN
            exp = tbl[i].exp_fwd;
`else
            exp = tbl[i].exp_full;
`endif
            apply(tbl[i].in);
            cyc_a(tbl[i].name);
            chk({tbl[i].name, ".tbl_ctrl"}, {bus.freeze_if, bus.flush_if, bus.flush_id}, exp);
            chk({tbl[i].name, ".tbl_fa"},   bus.freeze_all, 0);
            cyc_b();
        end

        // ---------------- branch beats hazard, flush_count +1 ----------------
        do_reset();
        apply(tbl[8].in);
        cyc_a("br_cnt");
        cyc_b();
        apply(zero_in());
        cyc_a("br_cnt_after");
        chk("br_cnt.flush_count", bus.flush_count, 1);
        chk("br_cnt.stall_count", bus.stall_count, 0);
        cyc_b();

        // ---------------- memory wait W=4, back-to-back, stall masks branch ----------------
        do_reset();
        v = zero_in();
        v.req = 1'b1;
        apply(v);
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                v.br = 1'b1;
                apply(v);
            end
            cyc_a("mem_seq");
            chk("mem_seq.freeze_all_hand", bus.freeze_all, ((c % 5) < 4) ? 1 : 0);
            chk("mem_seq.mem_done_hand",   bus.mem_done,   ((c % 5) == 4) ? 1 : 0);
            if (c == 4) chk("mem_seq.stall_after_first", bus.stall_count, 4);
            if (c >= 5) chk("mem_seq.flush_if_masked", bus.flush_if, (c == 9) ? 1 : 0);
            cyc_b();
        end
        apply(zero_in());
        cyc_a("mem_idle");
        chk("mem_idle.stall_count_hand", bus.stall_count, 8);
        chk("mem_idle.flush_count_hand", bus.flush_count, 1);
        cyc_b();

        // ---------------- reset mid-ACCESS ----------------
        do_reset();
        v = zero_in();
        v.req = 1'b1;
        apply(v);
        for (int c = 0; c < 2; c++) begin
            cyc_a("pre_abort");
            cyc_b();
        end
        // Now in the second ACCESS cycle; assert reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("abort.freeze_all",  bus.freeze_all,  0);
        chk("abort.mem_done",    bus.mem_done,    0);
        chk("abort.stall_count", bus.stall_count, 0);
        chk("abort.flush_count", bus.flush_count, 0);
        @(posedge clk);
        #1;
        chk("abort.mem_done_edge", bus.mem_done, 0);
        apply(zero_in());
        rst = 1'b0;
        model_reset();
        cyc_a("post_abort_idle");
        chk("post_abort.no_done", bus.mem_done, 0);
        cyc_b();
        apply(v);
        for (int c = 0; c < 6; c++) begin
            cyc_a("post_abort_access");
            cyc_b();
        end

        // ---------------- stall counter saturation ----------------
        do_reset();
        apply(tbl[3].in);
        for (int c = 0; c < 20; c++) begin
            cyc_a("sat");
            cyc_b();
        end
        apply(zero_in());
        cyc_a("sat_end");
        chk("sat.stall_count_hand", bus.stall_count, 15);
        chk("sat.flush_count_hand", bus.flush_count, 0);
        cyc_b();

        // ---------------- randomized run vs. model ----------------
        for (int n = 0; n < 400; n++) begin
            if ((n % 80) == 0) do_reset();
            v.src1 = 4'($urandom_range(0, 3));
            v.v1   = 1'($urandom_range(0, 1));
            v.src2 = 4'($urandom_range(0, 3));
            v.two  = 1'($urandom_range(0, 1));
            v.ed   = 4'($urandom_range(0, 3));
            v.ewb  = 1'($urandom_range(0, 1));
            v.erd  = 1'($urandom_range(0, 1));
            v.md   = 4'($urandom_range(0, 3));
            v.mwb  = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 5) == 0);
            v.req  = ($urandom_range(0, 3) == 0);
            apply(v);
            cyc_a("rand");
            cyc_b();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage ARM pipeline. It detects RAW hazards between the instruction in ID and the instructions in EXE/MEM, and squashes wrong-path instructions on a taken branch. It also sequences multi-cycle data-memory accesses with a wait-state FSM. Its outputs drive the PC/IF-ID hold, the IF-ID clear, the ID-EX pipeline register flush input and a global pipeline freeze, and it keeps saturating stall and flush counters for debug.

Parameters:
MEM_WAIT_CYCLES, 4, cycles the pipeline is frozen per data-memory access (0 = single-cycle memory, no stall)
CNT_WIDTH, 16, width of the stall/flush performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_src1  in  4  Rn index of the instruction in ID
id_src1_valid  in  1  ID instruction reads Rn
id_src2  in  4  second source (Rm, or Rd for STR)
id_two_src  in  1  ID instruction reads the second source
exe_dest  in  4  destination register in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_read  in  1  EXE instruction is a load
mem_dest  in  4  destination register in MEM
mem_wb_en  in  1  MEM instruction writes back
exe_branch_taken  in  1  taken branch resolved in EXE
mem_req  in  1  MEM-stage instruction performs a load or store
freeze_if  out  1  hold PC and IF/ID register
flush_if  out  1  clear IF/ID register
flush_id  out  1  insert bubble into ID/EX register (its flush input)
freeze_all  out  1  hold every pipeline register and PC
mem_done  out  1  one-cycle pulse: memory access complete
stall_count  out  CNT_WIDTH  cycles with freeze_if or freeze_all high
flush_count  out  CNT_WIDTH  cycles with flush_if high

Behaviour:
- Reset (async): FSM to IDLE, wait counter 0, both perf counters 0. All control outputs are 0 while rst is high.
- Hazard term (combinational). hz_exe = exe_wb_en & ((id_src1_valid & id_src1==exe_dest) | (id_two_src & id_src2==exe_dest)). hz_mem is the same expression using mem_wb_en and mem_dest. hazard = hz_exe | hz_mem.
- Priority, highest first: memory stall > taken branch > data hazard.
  - freeze_all = (state==IDLE & mem_req & MEM_WAIT_CYCLES!=0) | state==ACCESS.
  - Branch, when not freeze_all: flush_if=1, flush_id=1, freeze_if=0. The ID instruction is discarded, so hazard is ignored.
  - Hazard, when neither of the above: freeze_if=1, flush_id=1, flush_if=0.
  - While freeze_all=1: freeze_if, flush_if and flush_id are all 0.
- Memory FSM, states IDLE, ACCESS, DONE:
  - IDLE & mem_req & W>1: go to ACCESS, cnt<=1.
  - IDLE & mem_req & W==1: go to DONE.
  - IDLE & mem_req & W==0: stay in IDLE, mem_done=1 combinationally.
  - ACCESS: if cnt==W-1, go to DONE, else cnt<=cnt+1.
  - DONE: mem_done=1, freeze_all=0 so the pipeline advances, mem_req is ignored, then go to IDLE.
  - Each access therefore gives exactly W frozen cycles followed by one advancing cycle. Back-to-back memory instructions get W+1 cycles each.
  - A mem_req drop in ACCESS does not abort the access; the FSM completes the sequence.
- Counters update on the rising edge and saturate at all-ones with no wrap.
  - stall_count += 1 when freeze_if | freeze_all.
  - flush_count += 1 when flush_if.
- A reset asserted mid-access aborts immediately to IDLE. No mem_done pulse is emitted.

Optional Feature:
Macro HAZARD_FWD_EN.
- Defined: a forwarding unit covers EXE/MEM results. hazard = load-use only, i.e. exe_mem_read & hz_exe; hz_mem is ignored.
- Undefined: full interlock, hazard = hz_exe | hz_mem as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-ACCESS: assert rst in ACCESS cycle 2 -> state IDLE at once, freeze_all=0, no mem_done, counters 0.
- RAW hazard, feature off: id_src1=3, id_src1_valid=1, exe_dest=3, exe_wb_en=1 -> freeze_if=1, flush_id=1, flush_if=0. Repeat with mem_dest=3 instead -> same response. With HAZARD_FWD_EN defined, both cases -> 0 unless exe_mem_read=1.
- Branch vs hazard: exe_branch_taken=1 with the RAW hazard above -> flush_if=1, flush_id=1, freeze_if=0; flush_count increments by 1.
- Memory wait, W=4: mem_req held high from cycle 0 -> freeze_all=1 for cycles 0-3, mem_done=1 with freeze_all=0 in cycle 4. A second mem_req in cycle 5 restarts the sequence. stall_count=4 after the first access.
- Stall masks branch: exe_branch_taken=1 during freeze_all -> flush_if=0, flush_id=0 until the DONE cycle, where flush_if=1.
- Saturation, CNT_WIDTH=4: hold a hazard for 20 cycles -> stall_count stops at 15 and does not wrap.
